// File: rtl/math_adder_serial.sv
// math_adder_serial: bit-serial adder, one full-adder bit per clock, LSB first.
// Define MATH_ADDER_OVERFLOW_EN to add a registered signed-overflow output.
module math_adder_serial #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             carryIn,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             carryOut
`ifdef MATH_ADDER_OVERFLOW_EN
   ,
   output logic             overflow
`endif
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ADD  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;
   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   logic [1:0]       r_state;
   logic [WIDTH-1:0] r_a, r_b;
   logic [WIDTH-2:0] r_s;
   logic             r_c;
   logic [CW-1:0]    r_cnt;
   logic             w_s, w_c, w_last;
   logic [WIDTH-1:0] w_sh;

   assign w_s    = r_a[0] ^ r_b[0] ^ r_c;
   assign w_c    = (r_a[0] & r_b[0]) | (r_c & (r_a[0] ^ r_b[0]));
   assign w_last = r_cnt == CW'(WIDTH - 1);
   // new bit enters at the top; after the last bit w_sh is the full sum
   assign w_sh   = {w_s, r_s};
   assign busy   = r_state == S_ADD;
   assign done   = r_state == S_DONE;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_a      <= '0;
         r_b      <= '0;
         r_s      <= '0;
         r_c      <= 1'b0;
         r_cnt    <= '0;
         sum      <= '0;
         carryOut <= 1'b0;
      end else if (r_state == S_IDLE) begin
         if (start) begin
            r_a     <= A;
            r_b     <= B;
            r_c     <= carryIn;
            r_s     <= '0;
            r_cnt   <= '0;
            r_state <= S_ADD;
         end
      end else if (r_state == S_ADD) begin
         r_a   <= r_a >> 1;
         r_b   <= r_b >> 1;
         r_c   <= w_c;
         r_s   <= w_sh[WIDTH-1:1];
         r_cnt <= r_cnt + CW'(1);
         if (w_last) begin
            r_state  <= S_DONE;
            sum      <= w_sh;
            carryOut <= w_c;
         end
      end else begin
         r_state <= S_IDLE;
      end
   end

`ifdef MATH_ADDER_OVERFLOW_EN
   logic r_ov;
   assign overflow = r_ov;
   // at the last bit r_c is the carry into the MSB, w_c the carry out of it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_ov <= 1'b0;
      else if (r_state == S_ADD && w_last) r_ov <= r_c ^ w_c;
   end
`endif
endmodule

// File: tb/tb_math_adder_serial.sv
// tb_math_adder_serial: directed self-checking bench for math_adder_serial (WIDTH=8).
module tb_math_adder_serial;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [7:0] A = '0, B = '0;
   logic       carryIn = 1'b0;
   logic       busy, done, carryOut;
   logic [7:0] sum;
`ifdef MATH_ADDER_OVERFLOW_EN
   logic       overflow;
`endif
   int         n_chk = 0, n_err = 0;

   math_adder_serial #(.WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .carryIn(carryIn),
      .busy(busy), .done(done), .sum(sum), .carryOut(carryOut)
`ifdef MATH_ADDER_OVERFLOW_EN
      , .overflow(overflow)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // launch one operation, scramble inputs after acceptance, wait for done
   task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic ci, input logic [7:0] es, input logic ec);
      int lat, nb;
      @(negedge clk);
      start = 1'b1; A = a; B = b; carryIn = ci;
      @(posedge clk);
      #1 start = 1'b0; A = ~a; B = ~b; carryIn = ~ci;
      lat = 0; nb = 0;
      while (!done && lat < 50) begin
         if (busy) nb++;
         @(posedge clk);
         #1 lat++;
      end
      chk({tag, " latency"}, lat, 8);
      chk({tag, " busy cycles"}, nb, 8);
      chk({tag, " sum"}, sum, es);
      chk({tag, " carryOut"}, carryOut, ec);
      @(posedge clk);
      #1 chk({tag, " done one cycle"}, done, 0);
   endtask

   initial begin
      int nd, t1, t2, c;
      logic [7:0] s1, s2;
      repeat (2) @(posedge clk);
      #1;
      chk("reset busy", busy, 0);
      chk("reset done", done, 0);
      chk("reset sum", sum, 0);
      chk("reset carryOut", carryOut, 0);
      @(negedge clk) rst_n = 1'b1;

      do_op("5A+3C", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
`ifdef MATH_ADDER_OVERFLOW_EN
      chk("5A+3C overflow", overflow, 1);
`endif
      do_op("FF+01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
`ifdef MATH_ADDER_OVERFLOW_EN
      chk("FF+01 overflow", overflow, 0);
`endif
      do_op("00+00+1", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0);

      // start pulse during ADD must be ignored
      @(negedge clk);
      start = 1'b1; A = 8'h10; B = 8'h20; carryIn = 1'b0;
      @(negedge clk) start = 1'b0;
      @(negedge clk);
      @(negedge clk) begin start = 1'b1; A = 8'hFF; B = 8'hFF; end
      @(negedge clk) begin start = 1'b0; A = 8'h33; B = 8'h44; end
      nd = 0;
      repeat (20) begin
         @(posedge clk);
         #1 if (done) nd++;
      end
      chk("ignored start done count", nd, 1);
      chk("ignored start sum", sum, 8'h30);
      chk("ignored start carryOut", carryOut, 0);

      // asynchronous reset in the 4th ADD cycle
      @(negedge clk);
      start = 1'b1; A = 8'h5A; B = 8'h3C;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("abort busy", busy, 0);
      chk("abort done", done, 0);
      chk("abort sum", sum, 0);
      chk("abort carryOut", carryOut, 0);
      @(negedge clk) rst_n = 1'b1;
      nd = 0;
      repeat (12) begin
         @(posedge clk);
         #1 if (done) nd++;
      end
      chk("abort no done", nd, 0);
      do_op("80+80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1);
`ifdef MATH_ADDER_OVERFLOW_EN
      chk("80+80 overflow", overflow, 1);
`endif

      // start held high: back-to-back every WIDTH+2 cycles
      @(negedge clk);
      start = 1'b1; A = 8'h01; B = 8'h01; carryIn = 1'b0;
      @(posedge clk);
      #1 A = 8'h7F; B = 8'h01;
      t1 = -1; t2 = -1; s1 = '0; s2 = '0;
      for (c = 1; c <= 22; c++) begin
         @(posedge clk);
         #1 if (done) begin
            if (t1 < 0) begin t1 = c; s1 = sum; end
            else if (t2 < 0) begin
               t2 = c; s2 = sum;
`ifdef MATH_ADDER_OVERFLOW_EN
               chk("7F+01 overflow", overflow, 1);
`endif
            end
         end
      end
      start = 1'b0;
      chk("b2b first done", t1, 8);
      chk("b2b spacing", t2 - t1, 10);
      chk("b2b sum1", s1, 8'h02);
      chk("b2b sum2", s2, 8'h80);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/math_adder_serial.md
MATH_ADDER_SERIAL -- requirements
Module: math_adder_serial

Interface
REQ-001 Parameter: WIDTH, 8, operand/result width in bits (legal range 2..32).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: start  input  1  request to begin an addition; sampled on rising edge of clk.
REQ-005 Port: A  input  WIDTH  first operand, sampled only on an accepted start.
REQ-006 Port: B  input  WIDTH  second operand, sampled only on an accepted start.
REQ-007 Port: carryIn  input  1  initial carry, sampled only on an accepted start.
REQ-008 Port: busy  output  1  high while bits are being added.
REQ-009 Port: done  output  1  one-cycle pulse when sum/carryOut become valid.
REQ-010 Port: sum  output  WIDTH  registered result A+B+carryIn, modulo 2^WIDTH.
REQ-011 Port: carryOut  output  1  registered carry out of bit WIDTH-1.

Function
REQ-012 States: IDLE, ADD, DONE; encoding left to implementation.
REQ-013 IDLE: start=1 is accepted; A, B, carryIn latched into internal shift/carry registers; bit counter cleared; next state ADD.
REQ-014 IDLE: start=0 keeps IDLE; sum/carryOut hold their previous values.
REQ-015 ADD: each edge computes one full-adder bit, LSB first: s=a^b^c, c'=(a&b)|(c&(a^b)); counter increments.
REQ-016 ADD: after bit WIDTH-1 is processed (WIDTH edges after acceptance), carry register holds final carry; next state DONE.
REQ-017 DONE: lasts exactly one cycle; next state IDLE unconditionally.
REQ-018 busy = 1 iff state is ADD; done = 1 iff state is DONE.
REQ-019 Latency: done high during the cycle starting WIDTH edges after the edge that accepted start; next start accepted no earlier than the edge ending DONE +1 (i.e. in IDLE).
REQ-020 sum and carryOut update only on the edge entering DONE; stable and valid from done until the next result update.
REQ-021 start while in ADD or DONE is ignored; no queuing; operands of in-flight operation unaffected.
REQ-022 Changes on A/B/carryIn after acceptance have no effect on the result.
REQ-023 start held high continuously yields back-to-back operations, one every WIDTH+2 cycles.

Reset
REQ-024 rst_n low: immediately (asynchronously) state=IDLE, counter=0, internal registers=0, busy=0, done=0, sum=0, carryOut=0.
REQ-025 Reset asserted mid-ADD aborts the operation; no done pulse; sum/carryOut read 0.
REQ-026 First start acceptance is on the first rising edge with rst_n high and start high.

Configuration
REQ-027 Macro MATH_ADDER_OVERFLOW_EN defined: extra port overflow output 1, registered signed two's-complement overflow (carry into MSB XOR carry out of MSB), updated with sum, reset to 0.
REQ-028 Macro undefined: overflow port and its logic absent; all other behaviour identical.

Verification
REQ-029 WIDTH=8, A=0x5A, B=0x3C, carryIn=0, start one cycle -> busy 8 cycles, done pulse 8 edges after acceptance, sum=0x96, carryOut=0, overflow=1 (if enabled).
REQ-030 A=0xFF, B=0x01, carryIn=0 -> sum=0x00, carryOut=1, overflow=0; A=0x00, B=0x00, carryIn=1 -> sum=0x01, carryOut=0.
REQ-031 Start A=0x10,B=0x20; pulse start with A=0xFF,B=0xFF during ADD, change inputs -> single done, sum=0x30, carryOut=0.
REQ-032 rst_n low at 4th ADD cycle -> busy/done/sum/carryOut 0 immediately; no done pulse; subsequent A=0x80,B=0x80 -> sum=0x00, carryOut=1, overflow=1.
REQ-033 start held high, operands 0x01+0x01 then 0x7F+0x01 -> done pulses exactly 10 cycles apart, sums 0x02 then 0x80 (overflow=1).
